// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared state encodings, opcodes, ALU codes and the DECODE dispatch for mc_control_unit
package mc_ctrl_pkg;
    typedef enum logic [4:0] {
        RESET_S, FETCH, DECODE, EX_ASN, WB_ASNSH, EX_SHIFT, ORI_RD, ORI_EX, ORI_WB,
        LD_MEM, LD_WB, ST_MEM, BR_PZ, BR_Z, BR_NZ, NOP_S, STOP
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STOP  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_BZ    = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_NAND  = 4'b1000;
    localparam logic [3:0] OP_BNZ   = 4'b1001;
    localparam logic [3:0] OP_NOP   = 4'b1010;
    localparam logic [3:0] OP_BPZ   = 4'b1101;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_NAND  = 3'b011;
    localparam logic [2:0] ALU_SHIFT = 3'b100;

    localparam logic [2:0] ALU2_ONE   = 3'b001;
    localparam logic [2:0] ALU2_BOFS  = 3'b010;
    localparam logic [2:0] ALU2_IMM   = 3'b011;
    localparam logic [2:0] ALU2_SHAMT = 3'b100;

    // Undefined opcodes land in STOP as well; callers tell them apart from OP_STOP.
    function automatic state_t dispatch(input logic [3:0] op);
        casez (op)
            OP_ADD, OP_SUB, OP_NAND: dispatch = EX_ASN;
            4'b?011:                 dispatch = EX_SHIFT;
            4'b?111:                 dispatch = ORI_RD;
            OP_LOAD:                 dispatch = LD_MEM;
            OP_STORE:                dispatch = ST_MEM;
            OP_BPZ:                  dispatch = BR_PZ;
            OP_BZ:                   dispatch = BR_Z;
            OP_BNZ:                  dispatch = BR_NZ;
            OP_NOP:                  dispatch = NOP_S;
            default:                 dispatch = STOP;
        endcase
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit counter that increments on inc and holds at all-ones
// ports: clock, reset (sync, active-high, clears), inc, count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clock) begin
        if (reset)
            count <= '0;
        else if (inc && !(&count))
            count <= count + W'(1);
    end
endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle CPU control FSM with cycle/retired counters and illegal-opcode trap
// ports: clock, reset (sync, active-high); instr, N, Z, mem_ready, resume in;
// datapath controls, ALU2/ALUop, cycle_count, retired_count, retire, halted, illegal out
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter bit MEM_HANDSHAKE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       instr,
    input  logic             N,
    input  logic             Z,
    input  logic             mem_ready,
    input  logic             resume,
    output logic             PCwrite,
    output logic             AddrSel,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRload,
    output logic             R1Sel,
    output logic             MDRload,
    output logic             R1R2Load,
    output logic             ALU1,
    output logic             ALUOutWrite,
    output logic             RFWrite,
    output logic             RegIn,
    output logic             FlagWrite,
    output logic [2:0]       ALU2,
    output logic [2:0]       ALUop,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count,
    output logic             retire,
    output logic             halted,
    output logic             illegal
);
    state_t state;
    logic   rdy;

    assign rdy    = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign halted = state == STOP;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= RESET_S;
            illegal <= 1'b0;
        end else begin
            case (state)
                RESET_S:          state <= FETCH;
                FETCH:            if (rdy) state <= DECODE;
                DECODE: begin
                    state <= dispatch(instr);
                    if (dispatch(instr) == STOP && instr != OP_STOP)
                        illegal <= 1'b1;
                end
                EX_ASN, EX_SHIFT: state <= WB_ASNSH;
                ORI_RD:           state <= ORI_EX;
                ORI_EX:           state <= ORI_WB;
                LD_MEM:           if (rdy) state <= LD_WB;
                ST_MEM:           if (rdy) state <= FETCH;
                STOP: begin
                    if (resume) begin
                        state   <= FETCH;
                        illegal <= 1'b0;
                    end
                end
                default:          state <= FETCH;
            endcase
        end
    end

    always_comb begin
        PCwrite     = 1'b0;
        AddrSel     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRload      = 1'b0;
        R1Sel       = 1'b0;
        MDRload     = 1'b0;
        R1R2Load    = 1'b0;
        ALU1        = 1'b0;
        ALUOutWrite = 1'b0;
        RFWrite     = 1'b0;
        RegIn       = 1'b0;
        FlagWrite   = 1'b0;
        ALU2        = 3'b000;
        ALUop       = 3'b000;
        retire      = 1'b0;
        case (state)
            FETCH: begin
                AddrSel = 1'b1;
                MemRead = 1'b1;
                ALU2    = ALU2_ONE;
                ALUop   = ALU_ADD;
                PCwrite = rdy;
                IRload  = rdy;
            end
            DECODE: begin
                R1R2Load = 1'b1;
                retire   = instr == OP_STOP;
            end
            EX_ASN: begin
                ALU1        = 1'b1;
                ALUOutWrite = 1'b1;
                FlagWrite   = 1'b1;
                ALUop       = instr == OP_SUB ? ALU_SUB : instr == OP_NAND ? ALU_NAND : ALU_ADD;
            end
            EX_SHIFT: begin
                ALU1        = 1'b1;
                ALU2        = ALU2_SHAMT;
                ALUop       = ALU_SHIFT;
                ALUOutWrite = 1'b1;
                FlagWrite   = 1'b1;
            end
            WB_ASNSH: begin
                RFWrite = 1'b1;
                retire  = 1'b1;
            end
            ORI_RD: begin
                R1Sel    = 1'b1;
                R1R2Load = 1'b1;
            end
            ORI_EX: begin
                ALU1        = 1'b1;
                ALU2        = ALU2_IMM;
                ALUop       = ALU_OR;
                ALUOutWrite = 1'b1;
                FlagWrite   = 1'b1;
            end
            ORI_WB: begin
                R1Sel   = 1'b1;
                RFWrite = 1'b1;
                retire  = 1'b1;
            end
            LD_MEM: begin
                MemRead = 1'b1;
                MDRload = rdy;
            end
            LD_WB: begin
                ALUOutWrite = 1'b1;
                RFWrite     = 1'b1;
                RegIn       = 1'b1;
                retire      = 1'b1;
            end
            ST_MEM: begin
                MemWrite = 1'b1;
                retire   = rdy;
            end
            BR_PZ, BR_Z, BR_NZ: begin
                ALU2    = ALU2_BOFS;
                PCwrite = state == BR_PZ ? ~N : state == BR_Z ? Z : ~Z;
                retire  = 1'b1;
            end
            NOP_S:   retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    sat_counter #(.W(CNT_W)) u_cycles (
        .clock(clock),
        .reset(reset),
        .inc  (state != STOP),
        .count(cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_retired (
        .clock(clock),
        .reset(reset),
        .inc  (retire),
        .count(retired_count)
    );
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: directed and randomized checks of mc_control_unit against an instruction-step model
module tb_mc_control_unit;
    localparam int MAXC = 255;
    localparam int C_ASN = 0, C_SH = 1, C_ORI = 2, C_LD = 3, C_ST = 4, C_BR = 5, C_NOP = 6, C_HALT = 7, C_ILL = 8;

    typedef struct packed {
        logic pcw, addr, mrd, mwr, irl, r1s, mdr, r12, alu1, aow, rfw, regin, fw;
        logic [2:0] alu2, aluop;
        logic ret;
    } ctrl_t;

    logic clock = 1'b0;
    logic reset = 1'b1, N = 1'b0, Z = 1'b0, mem_ready = 1'b0, resume = 1'b0;
    logic [3:0] instr = 4'b0000;
    logic PCwrite, AddrSel, MemRead, MemWrite, IRload, R1Sel, MDRload, R1R2Load;
    logic ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite, retire, halted, illegal;
    logic [2:0] ALU2, ALUop;
    logic [7:0] cycle_count, retired_count;
    ctrl_t obs, last, e;

    int checks = 0, passed = 0;
    int j = 0, cc = 0, rc = 0;
    bit stopped = 0, ill = 0, in_rst = 0, known = 0;

    always #5 clock = ~clock;

    mc_control_unit #(.CNT_W(8), .MEM_HANDSHAKE(1)) dut (
        .clock(clock), .reset(reset), .instr(instr), .N(N), .Z(Z), .mem_ready(mem_ready),
        .resume(resume), .PCwrite(PCwrite), .AddrSel(AddrSel), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRload(IRload), .R1Sel(R1Sel), .MDRload(MDRload),
        .R1R2Load(R1R2Load), .ALU1(ALU1), .ALUOutWrite(ALUOutWrite), .RFWrite(RFWrite),
        .RegIn(RegIn), .FlagWrite(FlagWrite), .ALU2(ALU2), .ALUop(ALUop),
        .cycle_count(cycle_count), .retired_count(retired_count), .retire(retire),
        .halted(halted), .illegal(illegal)
    );

    assign obs = {PCwrite, AddrSel, MemRead, MemWrite, IRload, R1Sel, MDRload, R1R2Load,
                  ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite, ALU2, ALUop, retire};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int cls(input logic [3:0] op);
        case (op)
            4'b0100, 4'b0110, 4'b1000: return C_ASN;
            4'b0011, 4'b1011:          return C_SH;
            4'b0111, 4'b1111:          return C_ORI;
            4'b0000:                   return C_LD;
            4'b0010:                   return C_ST;
            4'b1101, 4'b0101, 4'b1001: return C_BR;
            4'b1010:                   return C_NOP;
            4'b0001:                   return C_HALT;
            default:                   return C_ILL;
        endcase
    endfunction

    function automatic int last_step(input int c);
        return c == C_ORI ? 4 : (c == C_ASN || c == C_SH || c == C_LD) ? 3 : 2;
    endfunction

    // Expected controls for step k of the instruction (0 fetch, 1 decode, 2.. execute).
    function automatic ctrl_t expect_ctrl(input logic [3:0] op, input int k, input bit rdy, input bit n, input bit z);
        ctrl_t c = '0;
        int    t = cls(op);
        if (in_rst || stopped) return c;
        if (k == 0) begin
            c.addr = 1; c.mrd = 1; c.alu2 = 3'd1; c.pcw = rdy; c.irl = rdy;
        end else if (k == 1) begin
            c.r12 = 1; c.ret = op == 4'b0001;
        end else if (t == C_ASN) begin
            if (k == 2) begin
                c.alu1 = 1; c.aow = 1; c.fw = 1;
                c.aluop = op == 4'b0110 ? 3'd1 : op == 4'b1000 ? 3'd3 : 3'd0;
            end else begin
                c.rfw = 1; c.ret = 1;
            end
        end else if (t == C_SH) begin
            if (k == 2) begin
                c.alu1 = 1; c.alu2 = 3'd4; c.aluop = 3'd4; c.aow = 1; c.fw = 1;
            end else begin
                c.rfw = 1; c.ret = 1;
            end
        end else if (t == C_ORI) begin
            if (k == 2) begin
                c.r1s = 1; c.r12 = 1;
            end else if (k == 3) begin
                c.alu1 = 1; c.alu2 = 3'd3; c.aluop = 3'd2; c.aow = 1; c.fw = 1;
            end else begin
                c.r1s = 1; c.rfw = 1; c.ret = 1;
            end
        end else if (t == C_LD) begin
            if (k == 2) begin
                c.mrd = 1; c.mdr = rdy;
            end else begin
                c.aow = 1; c.rfw = 1; c.regin = 1; c.ret = 1;
            end
        end else if (t == C_ST) begin
            c.mwr = 1; c.ret = rdy;
        end else if (t == C_BR) begin
            c.alu2 = 3'd2; c.ret = 1;
            c.pcw = op == 4'b1101 ? !n : op == 4'b0101 ? z : !z;
        end else if (t == C_NOP) begin
            c.ret = 1;
        end
        return c;
    endfunction

    task automatic cyc(input bit rst, input logic [3:0] op, input bit mr, input bit n, input bit z, input bit res);
        int t;
        @(negedge clock);
        reset = rst; instr = op; mem_ready = mr; N = n; Z = z; resume = res;
        #1;
        e = expect_ctrl(op, j, mr, n, z);
        last = obs;
        if (known) begin
            check("ctrl", obs, e);
            check("halted", halted, stopped);
            check("illegal", illegal, ill);
            check("cycle_count", cycle_count, cc);
            check("retired_count", retired_count, rc);
        end
        @(posedge clock);
        t = cls(op);
        if (rst) begin
            in_rst = 1; stopped = 0; ill = 0; cc = 0; rc = 0; j = 0; known = 1;
        end else begin
            if (!stopped) cc = cc < MAXC ? cc + 1 : MAXC;
            if (e.ret) rc = rc < MAXC ? rc + 1 : MAXC;
            if (in_rst) begin
                in_rst = 0; j = 0;
            end else if (stopped) begin
                if (res) begin stopped = 0; ill = 0; j = 0; end
            end else if (j == 0) begin
                if (mr) j = 1;
            end else if (j == 1) begin
                if (t == C_HALT) stopped = 1;
                else if (t == C_ILL) begin stopped = 1; ill = 1; end
                else j = 2;
            end else if (j == 2 && (t == C_LD || t == C_ST) && !mr) begin
                j = 2;
            end else if (j == last_step(t)) begin
                j = 0;
            end else begin
                j++;
            end
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input bit n, input bit z, output int k);
        cyc(0, op, 1, n, z, 0);
        k = 1;
        while (j != 0 && !stopped && k < 20) begin
            cyc(0, op, 1, n, z, 0);
            k++;
        end
        check("instr_bound", k < 20, 1);
    endtask

    task automatic branch(input logic [3:0] op, input bit n, input bit z, input bit exp);
        repeat (3) cyc(0, op, 1, n, z, 0);
        check("branch_pcwrite", last.pcw, exp);
    endtask

    initial begin
        int k, c0, r0;
        logic [3:0] cur;
        bit mr, res, rst;

        cyc(1, 4'b0100, 1, 0, 0, 0);
        #2;
        check("reset_ctrl", obs, 0);
        check("reset_cycles", cycle_count, 0);
        check("reset_halted", halted, 0);

        repeat (5) cyc(0, 4'b0100, 1, 0, 0, 0);
        check("add_retire_c5", last.ret, 1);
        #2;
        check("add_cycles", cycle_count, 5);
        check("add_retired", retired_count, 1);

        repeat (3) begin
            cyc(0, 4'b1010, 0, 0, 0, 0);
            check("fetch_wait_memread", last.mrd, 1);
            check("fetch_wait_pcwrite", last.pcw, 0);
        end
        cyc(0, 4'b1010, 1, 0, 0, 0);
        check("fetch_done_pcwrite", last.pcw, 1);
        check("fetch_done_irload", last.irl, 1);
        repeat (2) cyc(0, 4'b1010, 1, 0, 0, 0);

        branch(4'b0101, 0, 0, 0);
        branch(4'b1001, 0, 0, 1);
        branch(4'b1101, 1, 0, 0);
        branch(4'b1101, 0, 1, 1);

        run_instr(4'b1111, 0, 0, k);
        check("ori_len", k, 5);

        repeat (2) cyc(0, 4'b1100, 1, 0, 0, 0);
        #2;
        check("illegal_set", illegal, 1);
        check("illegal_halted", halted, 1);
        c0 = cycle_count;
        r0 = retired_count;
        repeat (10) cyc(0, 4'b1100, 1, 0, 0, 0);
        check("stop_cycles_frozen", cycle_count, c0);
        check("stop_retired_frozen", retired_count, r0);
        cyc(0, 4'b1100, 1, 0, 0, 1);
        #2;
        check("resume_illegal", illegal, 0);
        check("resume_halted", halted, 0);
        check("resume_keeps_count", cycle_count, c0);

        repeat (2) cyc(0, 4'b0000, 1, 0, 0, 0);
        cyc(0, 4'b0000, 0, 0, 0, 0);
        cyc(1, 4'b0000, 0, 0, 0, 1);
        #2;
        check("ldwait_reset_ctrl", obs, 0);
        check("ldwait_reset_cycles", cycle_count, 0);
        check("ldwait_reset_retired", retired_count, 0);

        repeat (301) run_instr(4'b1010, 0, 0, k);
        #2;
        check("sat_cycles", cycle_count, 255);
        check("sat_retired", retired_count, 255);

        cyc(1, 4'b1010, 1, 0, 0, 0);
        cur = 4'b1010;
        for (int i = 0; i < 3000; i++) begin
            if (j == 0 || stopped) begin
                cur = 4'($urandom_range(0, 15));
                if ((cur == 4'b0001 || cur == 4'b1100 || cur == 4'b1110) && $urandom_range(0, 2) != 0)
                    cur = 4'($urandom_range(0, 15));
            end
            mr  = $urandom_range(0, 3) != 0;
            res = stopped ? $urandom_range(0, 3) == 0 : 1'($urandom_range(0, 1));
            rst = $urandom_range(0, 199) == 0;
            cyc(rst, cur, mr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), res);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Parameter CNT_W, default 16: width of the cycle and retired-instruction counters (valid range 8..32).
REQ-002 Parameter MEM_HANDSHAKE, default 1: 1 = memory states wait for mem_ready; 0 = mem_ready is ignored and treated as 1.
REQ-003 Ports, one per line:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- instr  in  4  opcode field of the IR.
- N, Z  in  1 each  ALU flags.
- mem_ready  in  1  memory access completes this cycle.
- resume  in  1  leave STOP and restart fetch.
- PCwrite, AddrSel, MemRead, MemWrite, IRload, R1Sel, MDRload, R1R2Load, ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite  out  1 each  datapath controls.
- ALU2, ALUop  out  3 each  ALU source select and operation.
- cycle_count  out  CNT_W  cycles executed.
- retired_count  out  CNT_W  instructions completed.
- retire  out  1  pulse on the last cycle of each instruction.
- halted  out  1  FSM is in STOP.
- illegal  out  1  sticky flag: undefined opcode was decoded.

Function
REQ-004 States: RESET_S, FETCH, DECODE, EX_ASN, WB_ASNSH, EX_SHIFT, ORI_RD, ORI_EX, ORI_WB, LD_MEM, LD_WB, ST_MEM, BR_PZ, BR_Z, BR_NZ, NOP_S, STOP.
REQ-005 Fixed transitions: RESET_S->FETCH; DECODE->per REQ-006; EX_ASN/EX_SHIFT->WB_ASNSH->FETCH; ORI_RD->ORI_EX->ORI_WB->FETCH; LD_WB, branch states and NOP_S->FETCH.
REQ-006 DECODE dispatch:
- 0100/0110/1000 -> EX_ASN.
- instr[2:0]=011 -> EX_SHIFT.
- instr[2:0]=111 -> ORI_RD.
- 0000 -> LD_MEM; 0010 -> ST_MEM.
- 1101 -> BR_PZ; 0101 -> BR_Z; 1001 -> BR_NZ.
- 1010 -> NOP_S; 0001 -> STOP.
- Any other opcode -> STOP with illegal set.
REQ-007 FETCH: AddrSel=1, MemRead=1, ALU2=001, ALUop=000. PCwrite=IRload=mem_ready. Stay in FETCH while mem_ready=0; the PC is never incremented twice.
REQ-008 LD_MEM: MemRead=1, MDRload=mem_ready; stays until mem_ready=1. ST_MEM: MemWrite=1 held until mem_ready=1, then ->FETCH.
REQ-009 Per-state controls (all unlisted outputs are 0 in every state, including STOP):
- DECODE: R1R2Load=1.
- EX_ASN: ALU1=1, ALUOutWrite=1, FlagWrite=1; ALUop 000 add(0100), 001 sub(0110), 011 nand(1000).
- EX_SHIFT: ALU1=1, ALU2=100, ALUop=100, ALUOutWrite=1, FlagWrite=1.
- WB_ASNSH: RFWrite=1.
- ORI_RD: R1Sel=1, R1R2Load=1.
- ORI_EX: ALU1=1, ALU2=011, ALUop=010, ALUOutWrite=1, FlagWrite=1.
- ORI_WB: R1Sel=1, RFWrite=1.
- LD_WB: ALUOutWrite=1, RFWrite=1, RegIn=1.
REQ-010 Branch states: ALU2=010. PCwrite = ~N (BR_PZ), Z (BR_Z), ~Z (BR_NZ); N/Z are sampled in the same cycle.
REQ-011 retire=1 in: WB_ASNSH, ORI_WB, LD_WB, ST_MEM when mem_ready=1, branch states, NOP_S, and DECODE when it dispatches a legal 0001. retire=0 for an illegal opcode.
REQ-012 cycle_count increments on every clock edge where the state is not STOP, and saturates at all-ones.
REQ-013 retired_count increments when retire=1 and saturates at all-ones.
REQ-014 STOP: halted=1, counters frozen. resume=1 -> FETCH next cycle and clears illegal; the counters are not cleared.
REQ-015 resume is ignored outside STOP.
REQ-016 Outputs are a combinational function of the state register plus instr, N, Z, mem_ready; no latches, every output assigned in every state.

Reset
REQ-017 reset=1 at a clock edge forces RESET_S, cycle_count=0, retired_count=0, illegal=0, regardless of state, pending memory wait or resume.
REQ-018 In RESET_S all outputs are 0.
REQ-019 Reset wins over a simultaneous resume or mem_ready.

Structure
REQ-020 State encodings, opcode constants and ALUop/ALU2 codes live in a shared package (mc_ctrl_pkg).
REQ-021 One sub-module, sat_counter (parameter W; ports clock, reset, inc, count), is instantiated twice for the two counters.

Verification
REQ-022 Reset, then ADD (0100) with mem_ready=1 -> states FETCH, DECODE, EX_ASN, WB_ASNSH; retire pulse in cycle 5; cycle_count=5 and retired_count=1 after that edge.
REQ-023 FETCH with mem_ready low for 3 cycles -> MemRead=1 for 4 cycles, PCwrite/IRload high only in the 4th cycle.
REQ-024 BR_Z with Z=0 -> PCwrite=0; BR_NZ with Z=0 -> PCwrite=1; BR_PZ with N=1 -> PCwrite=0.
REQ-025 Opcode 1111 -> EX_SHIFT? No: instr[2:0]=111 -> ORI path of 5 cycles. Opcode 1100 -> STOP, illegal=1, halted=1, counters frozen for 10 cycles. Then resume=1 -> FETCH and illegal=0.
REQ-026 CNT_W=8 with 300 NOPs -> cycle_count holds at 255, no wrap.
REQ-027 reset asserted during LD_MEM wait (mem_ready=0) -> next state RESET_S, all outputs 0, counters 0.
